// File: rtl/io_command_issuer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | io_command_issuer: queues core IO commands and issues them in order   |
// | to an IO responder; returns register responses to writeback.          |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module io_command_issuer #(
    parameter int          FIFO_DEPTH   = 4,
    parameter int          TIMEOUT      = 64,
    parameter logic [15:0] TIMEOUT_DATA = 16'hFFFF
) (
    input  logic        clk,
    input  logic        sync_rst,
    input  logic        clk_en,
    input  logic        Cmd_Valid,
    output logic        Cmd_Ready,
    input  logic [15:0] Cmd_Data,
    input  logic [3:0]  Cmd_DestReg,
    input  logic        Cmd_ResponseRequested,
    output logic        IO_REQ,
    input  logic        IO_ACK,
    output logic        IO_CommandEn,
    output logic        IO_ResponseRequested,
    output logic [3:0]  IO_DestRegOut,
    output logic [15:0] IO_DataOut,
    input  logic        IO_CommandResponse,
    input  logic        IO_RegResponseFlag,
    input  logic [3:0]  IO_DestRegIn,
    input  logic [15:0] IO_DataIn,
    output logic        WB_Valid,
    input  logic        WB_Ack,
    output logic [3:0]  WB_DestReg,
    output logic [15:0] WB_Data,
    output logic        Timeout_Err,
    output logic        Tag_Mismatch,
    output logic        Busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WB    = 2'd2
    } state_t;

    // Entry layout: {response_requested, dest_reg, command_word}
    logic [20:0]      mem_q [FIFO_DEPTH];
    state_t           state_q, state_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [3:0]       tag_q, tag_d;
    logic [15:0]      wb_data_q, wb_data_d;
    logic             mismatch_q, mismatch_d;

    logic        empty, full, push, pop, resp_hit, timed_out;
    logic [20:0] head;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign head     = mem_q[rd_ptr_q];
    assign resp_hit = IO_CommandResponse && IO_RegResponseFlag;

    assign Cmd_Ready    = !full && !sync_rst;
    assign push         = Cmd_Valid && Cmd_Ready && clk_en;
    assign IO_REQ       = (state_q == ST_ISSUE) && !empty && !sync_rst;
    assign IO_CommandEn = IO_REQ;
    assign pop          = IO_REQ && IO_ACK && clk_en;

    assign IO_ResponseRequested = IO_REQ ? head[20]    : 1'b0;
    assign IO_DestRegOut        = IO_REQ ? head[19:16] : 4'd0;
    assign IO_DataOut           = IO_REQ ? head[15:0]  : 16'd0;

    // A response in the final wait cycle takes priority over the timeout.
    assign timed_out   = (state_q == ST_WAIT) && (timer_q == TMR_W'(TIMEOUT - 1)) && !resp_hit;
    assign Timeout_Err = timed_out && !sync_rst;

    assign WB_Valid     = (state_q == ST_WB) && !sync_rst;
    assign WB_DestReg   = WB_Valid ? tag_q : 4'd0;
    assign WB_Data      = WB_Valid ? wb_data_q : 16'd0;
    assign Tag_Mismatch = mismatch_q && !sync_rst;
    assign Busy         = !sync_rst && (!empty || (state_q != ST_ISSUE));

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        tag_d      = tag_q;
        wb_data_d  = wb_data_q;
        mismatch_d = mismatch_q;
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        count_d    = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

        case (state_q)
            ST_ISSUE: begin
                if (pop) begin
                    tag_d = head[19:16];
                    if (head[20]) begin
                        if (resp_hit) begin
                            wb_data_d = IO_DataIn;
                            if (IO_DestRegIn != head[19:16]) mismatch_d = 1'b1;
                            state_d = ST_WB;
                        end else begin
                            timer_d = TMR_W'(1);
                            state_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (resp_hit) begin
                    wb_data_d = IO_DataIn;
                    if (IO_DestRegIn != tag_q) mismatch_d = 1'b1;
                    state_d = ST_WB;
                end else if (timed_out) begin
                    wb_data_d = TIMEOUT_DATA;
                    state_d   = ST_WB;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_WB: begin
                if (WB_Ack) state_d = ST_ISSUE;
            end
            default: state_d = ST_ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q    <= ST_ISSUE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            timer_q    <= '0;
            tag_q      <= '0;
            wb_data_q  <= '0;
            mismatch_q <= 1'b0;
        end else if (clk_en) begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            tag_q      <= tag_d;
            wb_data_q  <= wb_data_d;
            mismatch_q <= mismatch_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {Cmd_ResponseRequested, Cmd_DestReg, Cmd_Data};
    end

endmodule
`default_nettype wire

// File: tb/tb_io_command_issuer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_io_command_issuer: directed bench with a queue-based reference     |
// | model of the IO command bus initiator.                                |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_io_command_issuer;

    localparam int          DEPTH = 4;
    localparam int          TMO   = 64;
    localparam logic [15:0] TDATA = 16'hFFFF;

    logic        clk = 1'b0;
    logic        sync_rst, clk_en;
    logic        Cmd_Valid, Cmd_Ready, Cmd_ResponseRequested;
    logic [15:0] Cmd_Data;
    logic [3:0]  Cmd_DestReg;
    logic        IO_REQ, IO_ACK, IO_CommandEn, IO_ResponseRequested;
    logic [3:0]  IO_DestRegOut, IO_DestRegIn;
    logic [15:0] IO_DataOut, IO_DataIn;
    logic        IO_CommandResponse, IO_RegResponseFlag;
    logic        WB_Valid, WB_Ack;
    logic [3:0]  WB_DestReg;
    logic [15:0] WB_Data;
    logic        Timeout_Err, Tag_Mismatch, Busy;

    io_command_issuer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .TIMEOUT_DATA(TDATA)) dut (
        .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
        .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Data(Cmd_Data),
        .Cmd_DestReg(Cmd_DestReg), .Cmd_ResponseRequested(Cmd_ResponseRequested),
        .IO_REQ(IO_REQ), .IO_ACK(IO_ACK), .IO_CommandEn(IO_CommandEn),
        .IO_ResponseRequested(IO_ResponseRequested), .IO_DestRegOut(IO_DestRegOut),
        .IO_DataOut(IO_DataOut), .IO_CommandResponse(IO_CommandResponse),
        .IO_RegResponseFlag(IO_RegResponseFlag), .IO_DestRegIn(IO_DestRegIn),
        .IO_DataIn(IO_DataIn), .WB_Valid(WB_Valid), .WB_Ack(WB_Ack),
        .WB_DestReg(WB_DestReg), .WB_Data(WB_Data), .Timeout_Err(Timeout_Err),
        .Tag_Mismatch(Tag_Mismatch), .Busy(Busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit run_cmp = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending commands as a queue, plus what the bus is doing.
    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  t;
        logic        r;
    } ent_t;

    ent_t        mq[$];
    int          m_phase = 0;    // 0 issuing, 1 awaiting response, 2 writeback pending
    int          en_cyc  = 0;    // enabled cycles elapsed
    int          acc_cyc = 0;    // enabled cycle of the accepting handshake
    logic [3:0]  m_tag   = '0;
    logic [15:0] m_wb    = '0;
    logic        m_mism  = 1'b0;

    always @(posedge clk) begin
        bit   room, resp;
        ent_t e;
        if (sync_rst) begin
            mq.delete();
            m_phase = 0;
            m_mism  = 1'b0;
        end else if (clk_en) begin
            room = mq.size() < DEPTH;
            resp = IO_CommandResponse && IO_RegResponseFlag;
            if (m_phase == 0 && mq.size() > 0 && IO_ACK) begin
                e = mq.pop_front();
                m_tag = e.t;
                if (e.r && resp) begin
                    m_wb = IO_DataIn;
                    if (IO_DestRegIn != e.t) m_mism = 1'b1;
                    m_phase = 2;
                end else if (e.r) begin
                    acc_cyc = en_cyc;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (resp) begin
                    m_wb = IO_DataIn;
                    if (IO_DestRegIn != m_tag) m_mism = 1'b1;
                    m_phase = 2;
                end else if (en_cyc - acc_cyc == TMO - 1) begin
                    m_wb = TDATA;
                    m_phase = 2;
                end
            end else if (m_phase == 2 && WB_Ack) begin
                m_phase = 0;
            end
            if (Cmd_Valid && room) mq.push_back('{Cmd_Data, Cmd_DestReg, Cmd_ResponseRequested});
            en_cyc++;
        end
    end

    always @(negedge clk) begin
        logic        rst_n, req, wbv, tmo;
        ent_t        h;
        if (run_cmp) begin
            rst_n = !sync_rst;
            req   = rst_n && m_phase == 0 && mq.size() > 0;
            h     = req ? mq[0] : '0;
            wbv   = rst_n && m_phase == 2;
            tmo   = rst_n && m_phase == 1 && (en_cyc - acc_cyc == TMO - 1)
                    && !(IO_CommandResponse && IO_RegResponseFlag);
            check("Cmd_Ready", Cmd_Ready, rst_n && mq.size() < DEPTH);
            check("IO_REQ", IO_REQ, req);
            check("IO_CommandEn", IO_CommandEn, req);
            check("IO_ResponseRequested", IO_ResponseRequested, h.r);
            check("IO_DestRegOut", IO_DestRegOut, h.t);
            check("IO_DataOut", IO_DataOut, h.d);
            check("WB_Valid", WB_Valid, wbv);
            check("WB_DestReg", WB_DestReg, wbv ? m_tag : 4'd0);
            check("WB_Data", WB_Data, wbv ? m_wb : 16'd0);
            check("Timeout_Err", Timeout_Err, tmo);
            check("Tag_Mismatch", Tag_Mismatch, rst_n && m_mism);
            check("Busy", Busy, rst_n && (mq.size() > 0 || m_phase != 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [15:0] d, input logic [3:0] t, input logic r);
        Cmd_Valid = 1'b1; Cmd_Data = d; Cmd_DestReg = t; Cmd_ResponseRequested = r;
    endtask

    task automatic respond(input logic on, input logic [3:0] t, input logic [15:0] d);
        IO_CommandResponse = on; IO_RegResponseFlag = on; IO_DestRegIn = t; IO_DataIn = d;
    endtask

    initial begin
        logic [15:0] bp [5];
        int k, guard;
        logic rdy;
        bp[0] = 16'h2011; bp[1] = 16'h2022; bp[2] = 16'h2033; bp[3] = 16'h2044; bp[4] = 16'h2055;

        sync_rst = 1'b1; clk_en = 1'b1;
        Cmd_Valid = 1'b0; Cmd_Data = '0; Cmd_DestReg = '0; Cmd_ResponseRequested = 1'b0;
        IO_ACK = 1'b0; WB_Ack = 1'b0;
        respond(1'b0, 4'd0, 16'd0);
        tick();
        run_cmp = 1'b1;
        tick();
        #1 check("rst Cmd_Ready", Cmd_Ready, 1'b0);
        tick(); sync_rst = 1'b0;
        #1 check("post-rst Cmd_Ready", Cmd_Ready, 1'b1);
        check("post-rst Busy", Busy, 1'b0);

        // Zero-latency read
        cmd(16'h1000, 4'd3, 1'b1); IO_ACK = 1'b1; respond(1'b1, 4'd3, 16'h0001);
        tick(); Cmd_Valid = 1'b0;
        #1 check("zl IO_REQ N+1", IO_REQ, 1'b1);
        check("zl IO_DataOut", IO_DataOut, 16'h1000);
        tick();
        #1 check("zl WB_Valid N+2", WB_Valid, 1'b1);
        check("zl WB_DestReg", WB_DestReg, 4'd3);
        check("zl WB_Data", WB_Data, 16'h0001);
        check("zl Tag_Mismatch", Tag_Mismatch, 1'b0);
        WB_Ack = 1'b1;
        tick(); WB_Ack = 1'b0; respond(1'b0, 4'd0, 16'd0);

        // Write stream
        cmd(16'h2001, 4'd0, 1'b0);
        tick(); Cmd_Data = 16'h4001;
        #1 check("ws data0", IO_DataOut, 16'h2001);
        tick(); Cmd_Data = 16'h6001;
        #1 check("ws data1", IO_DataOut, 16'h4001);
        tick(); Cmd_Valid = 1'b0;
        #1 check("ws data2", IO_DataOut, 16'h6001);
        check("ws req2", IO_REQ, 1'b1);
        tick();
        #1 check("ws req idle", IO_REQ, 1'b0);
        check("ws Busy", Busy, 1'b0);

        // Back-pressure
        IO_ACK = 1'b0;
        cmd(bp[0], 4'd1, 1'b0);
        k = 0; guard = 0;
        while (k < DEPTH && guard < 20) begin
            #1 rdy = Cmd_Ready;
            tick(); guard++;
            if (rdy) begin k++; Cmd_Data = bp[k]; end
        end
        #1 check("bp accepts", k, DEPTH);
        check("bp Cmd_Ready full", Cmd_Ready, 1'b0);
        IO_ACK = 1'b1;
        tick();
        #1 check("bp Cmd_Ready after pop", Cmd_Ready, 1'b1);
        check("bp head after pop", IO_DataOut, bp[1]);
        tick(); Cmd_Valid = 1'b0;
        guard = 0;
        while (Busy && guard < 20) begin tick(); guard++; end
        check("bp drain bound", guard < 20, 1'b1);

        // Timeout
        cmd(16'h1000, 4'd5, 1'b1);
        tick(); Cmd_Valid = 1'b0;
        #1 check("to IO_REQ", IO_REQ, 1'b1);
        tick(); IO_ACK = 1'b0;
        k = 1;
        while (!Timeout_Err && k < 200) begin tick(); k++; #1; end
        check("to latency", k, TMO - 1);
        tick();
        #1 check("to WB_Data", WB_Data, 16'hFFFF);
        check("to WB_DestReg", WB_DestReg, 4'd5);
        WB_Ack = 1'b1;
        tick(); WB_Ack = 1'b0;

        // Delayed response, tag mismatch, writeback stall with clk_en gap
        IO_ACK = 1'b1; cmd(16'h1000, 4'd2, 1'b1);
        tick(); Cmd_Valid = 1'b0;
        tick(); IO_ACK = 1'b0;
        tick(); cmd(16'h2005, 4'd0, 1'b0);
        tick(); Cmd_Valid = 1'b0;
        tick();
        tick(); respond(1'b1, 4'd7, 16'h00A5); IO_ACK = 1'b1;
        tick(); respond(1'b0, 4'd0, 16'd0);
        #1 check("dr WB_Data", WB_Data, 16'h00A5);
        check("dr WB_DestReg", WB_DestReg, 4'd2);
        check("dr Tag_Mismatch", Tag_Mismatch, 1'b1);
        tick(); clk_en = 1'b0;
        #1 check("dr WB_Data held", WB_Data, 16'h00A5);
        tick(); clk_en = 1'b1;
        tick(); WB_Ack = 1'b1;
        #1 check("dr no REQ in WB", IO_REQ, 1'b0);
        tick(); WB_Ack = 1'b0;
        #1 check("dr REQ after ack", IO_REQ, 1'b1);
        check("dr next cmd", IO_DataOut, 16'h2005);
        tick();

        // Reset while waiting with two queued entries
        cmd(16'h1000, 4'd4, 1'b1);
        tick(); Cmd_Valid = 1'b0;
        tick(); IO_ACK = 1'b0; cmd(16'h2001, 4'd0, 1'b0);
        tick(); Cmd_Data = 16'h2002;
        tick(); Cmd_Valid = 1'b0;
        #1 check("rw Busy before rst", Busy, 1'b1);
        sync_rst = 1'b1;
        tick(); sync_rst = 1'b0;
        #1 check("rw Busy", Busy, 1'b0);
        check("rw Tag_Mismatch", Tag_Mismatch, 1'b0);
        respond(1'b1, 4'd4, 16'h1234);
        tick(); respond(1'b0, 4'd0, 16'd0);
        tick();
        #1 check("rw late resp WB_Valid", WB_Valid, 1'b0);
        check("rw IO_REQ", IO_REQ, 1'b0);
        tick();

        run_cmp = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
